// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO peripheral responder:
// register word offsets, TCON bit positions and DIGI width.
package mmio_pkg;

  localparam int DIGI_W = 12;

  // Word offsets, i.e. iMemAddr[4:2]
  localparam logic [2:0] OFS_TH      = 3'd0;
  localparam logic [2:0] OFS_TL      = 3'd1;
  localparam logic [2:0] OFS_TCON    = 3'd2;
  localparam logic [2:0] OFS_LED     = 3'd3;
  localparam logic [2:0] OFS_SWITCH  = 3'd4;
  localparam logic [2:0] OFS_DIGI    = 3'd5;
  localparam logic [2:0] OFS_SYSTICK = 3'd6;

  localparam int TCON_RUN = 0;
  localparam int TCON_IE  = 1;
  localparam int TCON_IS  = 2;

endpackage

// File: rtl/mmio_timer.sv
// Reloading 32-bit timer: TH reload value, TL count, TCON {IS,IE,RUN}.
// Ports: clk, reset, wr_*_i write strobes, wdata_i, th_o/tl_o/tcon_o.
module mmio_timer
  import mmio_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_th_i,
  input  logic        wr_tl_i,
  input  logic        wr_tcon_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] th_o,
  output logic [31:0] tl_o,
  output logic [2:0]  tcon_o
);

  logic [31:0] th_q, th_d;
  logic [31:0] tl_q, tl_d;
  logic [2:0]  tcon_q, tcon_d;
  logic        ovf;

  assign ovf = tcon_q[TCON_RUN] & (tl_q == 32'hFFFF_FFFF);

  always_comb begin
    th_d   = wr_th_i ? wdata_i : th_q;
    tl_d   = tl_q;
    tcon_d = tcon_q;
    if (tcon_q[TCON_RUN]) begin
      // reload takes the pre-write TH
      tl_d = ovf ? th_q : tl_q + 32'd1;
    end
    if (wr_tl_i) begin
      tl_d = wdata_i;
    end
    if (wr_tcon_i) begin
      tcon_d = wdata_i[2:0];
    end
    // overflow set wins over a software clear
    if (ovf && tcon_q[TCON_IE]) begin
      tcon_d[TCON_IS] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      th_q   <= '0;
      tl_q   <= '0;
      tcon_q <= '0;
    end else begin
      th_q   <= th_d;
      tl_q   <= tl_d;
      tcon_q <= tcon_d;
    end
  end

  assign th_o   = th_q;
  assign tl_o   = tl_q;
  assign tcon_o = tcon_q;

endmodule

// File: rtl/mmio_peripheral_responder.sv
// MMIO responder: 32-byte window with timer, LED, switch, 7-seg, SYSTICK.
// Ports: clk, reset (async high), iMem* bus, oMemReadData, oInterrupt,
// oLed, oDigi, iSwitch. Macro MMIO_SYSTICK_EN adds the SYSTICK counter.
module mmio_peripheral_responder
  import mmio_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8,
  parameter int          SW_W      = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       iMemAddr,
  input  logic              iMemRead,
  input  logic              iMemWrite,
  input  logic [31:0]       iMemWriteData,
  output logic [31:0]       oMemReadData,
  output logic              oInterrupt,
  output logic [LED_W-1:0]  oLed,
  output logic [DIGI_W-1:0] oDigi,
  input  logic [SW_W-1:0]   iSwitch
);

  logic              hit;
  logic              wr;
  logic [2:0]        ofs;
  logic [31:0]       th, tl;
  logic [2:0]        tcon;
  logic [LED_W-1:0]  led_q, led_d;
  logic [DIGI_W-1:0] digi_q, digi_d;
  logic [SW_W-1:0]   sw_meta_q, sw_sync_q;
  logic [31:0]       rdata;

  assign hit = (iMemAddr[31:5] == BASE_ADDR[31:5])
             & (iMemAddr[1:0] == 2'b00);
  assign ofs = iMemAddr[4:2];
  assign wr  = iMemWrite & hit;

  mmio_timer u_timer (
    .clk       (clk),
    .reset     (reset),
    .wr_th_i   (wr && ofs == OFS_TH),
    .wr_tl_i   (wr && ofs == OFS_TL),
    .wr_tcon_i (wr && ofs == OFS_TCON),
    .wdata_i   (iMemWriteData),
    .th_o      (th),
    .tl_o      (tl),
    .tcon_o    (tcon)
  );

  always_comb begin
    led_d  = led_q;
    digi_d = digi_q;
    if (wr && ofs == OFS_LED) begin
      led_d = iMemWriteData[LED_W-1:0];
    end
    if (wr && ofs == OFS_DIGI) begin
      digi_d = iMemWriteData[DIGI_W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q     <= '0;
      digi_q    <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      digi_q    <= digi_d;
      sw_meta_q <= iSwitch;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef MMIO_SYSTICK_EN
  logic [31:0] systick_q, systick_d;

  assign systick_d = systick_q + 32'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      systick_q <= '0;
    end else begin
      systick_q <= systick_d;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    if (iMemRead && hit) begin
      unique case (ofs)
        OFS_TH:      rdata = th;
        OFS_TL:      rdata = tl;
        OFS_TCON:    rdata = 32'(tcon);
        OFS_LED:     rdata = 32'(led_q);
        OFS_SWITCH:  rdata = 32'(sw_sync_q);
        OFS_DIGI:    rdata = 32'(digi_q);
`ifdef MMIO_SYSTICK_EN
        OFS_SYSTICK: rdata = systick_q;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign oMemReadData = rdata;
  assign oInterrupt   = tcon[TCON_IS] & tcon[TCON_IE];
  assign oLed         = led_q;
  assign oDigi        = digi_q;

endmodule

// File: tb/tb_mmio_peripheral_responder.sv
// Self-checking bench for mmio_peripheral_responder: directed
// scenarios plus randomized bus traffic against a register-map model.
module tb_mmio_peripheral_responder;

  localparam logic [31:0] BASE = 32'h4000_0000;

  logic        clk;
  logic        reset;
  logic [31:0] iMemAddr;
  logic        iMemRead;
  logic        iMemWrite;
  logic [31:0] iMemWriteData;
  logic [31:0] oMemReadData;
  logic        oInterrupt;
  logic [7:0]  oLed;
  logic [11:0] oDigi;
  logic [7:0]  iSwitch;

  int checks;
  int failures;

  // reference register map
  logic [31:0] m_th, m_tl, m_st;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led, m_s1, m_s2;
  logic [11:0] m_digi;

  mmio_peripheral_responder dut (
    .clk           (clk),
    .reset         (reset),
    .iMemAddr      (iMemAddr),
    .iMemRead      (iMemRead),
    .iMemWrite     (iMemWrite),
    .iMemWriteData (iMemWriteData),
    .oMemReadData  (oMemReadData),
    .oInterrupt    (oInterrupt),
    .oLed          (oLed),
    .oDigi         (oDigi),
    .iSwitch       (iSwitch)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic in_win(input logic [31:0] a);
    return (a[31:5] == BASE[31:5]) && (a[1:0] == 2'b00);
  endfunction

  function automatic logic [31:0] m_rd(input logic rd,
                                       input logic [31:0] a);
    logic [31:0] v;
    v = 32'd0;
    if (rd && in_win(a)) begin
      case (a[4:2])
        3'd0: v = m_th;
        3'd1: v = m_tl;
        3'd2: v = {29'd0, m_tcon};
        3'd3: v = {24'd0, m_led};
        3'd4: v = {24'd0, m_s2};
        3'd5: v = {20'd0, m_digi};
`ifdef MMIO_SYSTICK_EN
        3'd6: v = m_st;
`endif
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic m_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0;
    m_digi = 0; m_s1 = 0; m_s2 = 0; m_st = 0;
  endtask

  // one clock edge of the register map
  task automatic m_step(input logic wr, input logic [31:0] a,
                        input logic [31:0] wd);
    logic        wrap;
    logic [31:0] tl_n;
    logic [2:0]  tcon_n;
    wrap   = m_tcon[0] && (m_tl == 32'hFFFF_FFFF);
    tl_n   = m_tl;
    if (m_tcon[0]) tl_n = wrap ? m_th : m_tl + 1;
    tcon_n = m_tcon;
    if (wr && in_win(a)) begin
      case (a[4:2])
        3'd0: m_th = wd;
        3'd1: tl_n = wd;
        3'd2: tcon_n = wd[2:0];
        3'd3: m_led = wd[7:0];
        3'd5: m_digi = wd[11:0];
        default: ;
      endcase
    end
    if (wrap && m_tcon[1]) tcon_n[2] = 1'b1;
    m_tl   = tl_n;
    m_tcon = tcon_n;
    m_s2   = m_s1;
    m_s1   = iSwitch;
    m_st   = m_st + 1;
  endtask

  // one bus cycle: starts and ends at a negedge
  task automatic bus(input logic rd, input logic wr,
                     input logic [31:0] a, input logic [31:0] wd,
                     output logic [31:0] r);
    iMemRead      = rd;
    iMemWrite     = wr;
    iMemAddr      = a;
    iMemWriteData = wd;
    #1;
    r = oMemReadData;
    chk("rdata", r, m_rd(rd, a));
    @(posedge clk);
    m_step(wr, a, wd);
    @(negedge clk);
    chk("irq", oInterrupt, m_tcon[2] & m_tcon[1]);
    chk("led", oLed, m_led);
    chk("digi", oDigi, m_digi);
    iMemRead  = 1'b0;
    iMemWrite = 1'b0;
  endtask

  task automatic wr_reg(input logic [31:0] a, input logic [31:0] d);
    logic [31:0] r;
    bus(1'b0, 1'b1, a, d, r);
  endtask

  task automatic rd_reg(input logic [31:0] a, output logic [31:0] r);
    bus(1'b1, 1'b0, a, 32'd0, r);
  endtask

  task automatic idle();
    logic [31:0] r;
    bus(1'b0, 1'b0, BASE, 32'd0, r);
  endtask

  logic [31:0] r, r0;

  initial begin
    checks = 0; failures = 0;
    reset = 1'b1;
    iMemAddr = 0; iMemRead = 0; iMemWrite = 0;
    iMemWriteData = 0; iSwitch = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_irq", oInterrupt, 1'b0);
    chk("rst_led", oLed, 8'h00);
    rd_reg(BASE + 4, r);  chk("rst_tl", r, 32'd0);
    rd_reg(BASE + 8, r);  chk("rst_tcon", r, 32'd0);
    rd_reg(BASE + 20, r); chk("rst_digi", r, 32'd0);

    // decode
    wr_reg(BASE + 12, 32'h0000_00A5);
    chk("led_a5", oLed, 8'hA5);
    wr_reg(32'h4000_0020, 32'h0000_005A);
    chk("led_miss", oLed, 8'hA5);
    rd_reg(32'h4000_0020, r); chk("rd_miss", r, 32'd0);
    rd_reg(BASE + 13, r);     chk("rd_misal", r, 32'd0);
    bus(1'b0, 1'b0, BASE + 12, 32'd0, r);
    chk("rd_noread", r, 32'd0);
    wr_reg(BASE + 20, 32'hFFFF_F123);
    chk("digi_w", oDigi, 12'h123);
    wr_reg(BASE + 16, 32'h0000_0077);
    rd_reg(BASE + 16, r); chk("sw_ro", r, 32'd0);

    // reload with IRQ enabled
    wr_reg(BASE + 0, 32'hFFFF_FFFD);
    wr_reg(BASE + 4, 32'hFFFF_FFFE);
    wr_reg(BASE + 8, 32'd3);
    rd_reg(BASE + 4, r); chk("tl_seq0", r, 32'hFFFF_FFFE);
    rd_reg(BASE + 4, r); chk("tl_seq1", r, 32'hFFFF_FFFF);
    chk("irq_set", oInterrupt, 1'b1);
    rd_reg(BASE + 4, r); chk("tl_seq2", r, 32'hFFFF_FFFD);
    rd_reg(BASE + 4, r); chk("tl_seq3", r, 32'hFFFF_FFFE);
    rd_reg(BASE + 8, r); chk("tcon_7", r, 32'd7);

    // IRQ disabled: wrap reloads without status
    wr_reg(BASE + 8, 32'd0);
    chk("irq_clr", oInterrupt, 1'b0);
    wr_reg(BASE + 4, 32'hFFFF_FFFE);
    wr_reg(BASE + 8, 32'd1);
    idle();
    idle();
    rd_reg(BASE + 4, r); chk("ie_off_tl", r, 32'hFFFF_FFFD);
    rd_reg(BASE + 8, r); chk("ie_off_tcon", r, 32'd1);
    chk("ie_off_irq", oInterrupt, 1'b0);

    // status set beats software clear
    wr_reg(BASE + 8, 32'd0);
    wr_reg(BASE + 0, 32'h0000_0010);
    wr_reg(BASE + 4, 32'hFFFF_FFFE);
    wr_reg(BASE + 8, 32'd3);
    idle();
    wr_reg(BASE + 8, 32'd3);
    rd_reg(BASE + 8, r); chk("sbc_tcon", r, 32'd7);
    chk("sbc_irq", oInterrupt, 1'b1);
    wr_reg(BASE + 8, 32'd3);
    chk("sw_clr_irq", oInterrupt, 1'b0);

    // switch synchronizer latency
    iSwitch = 8'h00;
    idle(); idle();
    iSwitch = 8'h3C;
    rd_reg(BASE + 16, r); chk("sw_lat0", r, 32'd0);
    rd_reg(BASE + 16, r); chk("sw_lat1", r, 32'd0);
    rd_reg(BASE + 16, r); chk("sw_lat2", r, 32'h3C);

    // SYSTICK
    rd_reg(BASE + 24, r0);
    idle(); idle(); idle(); idle();
    rd_reg(BASE + 24, r);
`ifdef MMIO_SYSTICK_EN
    chk("systick_k", r, r0 + 32'd5);
`else
    chk("systick_off", r, 32'd0);
`endif

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      int          kind;
      logic [31:0] a, d;
      logic        rd, wr;
      kind = $urandom_range(0, 9);
      a = BASE + {27'd0, 3'($urandom_range(0, 7)), 2'b00};
      if (kind == 0) a = BASE + 32'h20 + {27'd0, 3'($urandom), 2'b00};
      if (kind == 1) a = a | 32'($urandom_range(1, 3));
      d  = $urandom;
      if (a[4:2] == 3'd1 && $urandom_range(0, 1) == 1)
        d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
      if (a[4:2] == 3'd2 && $urandom_range(0, 3) != 0)
        d = d | 32'd1;
      rd = 1'($urandom);
      wr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) iSwitch = 8'($urandom);
      bus(rd, wr, a, d, r);
    end

    // async reset mid-count
    wr_reg(BASE + 12, 32'h0000_0042);
    wr_reg(BASE + 4, 32'h0000_1000);
    wr_reg(BASE + 8, 32'd3);
    idle(); idle();
    iMemRead = 1'b1;
    iMemAddr = BASE + 4;
    #2;
    reset = 1'b1;
    m_reset();
    #1;
    chk("arst_tl", oMemReadData, 32'd0);
    iMemAddr = BASE + 8;
    #1;
    chk("arst_tcon", oMemReadData, 32'd0);
    chk("arst_led", oLed, 8'h00);
    chk("arst_irq", oInterrupt, 1'b0);
    iMemRead = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    rd_reg(BASE + 4, r); chk("post_rst_tl", r, 32'd0);
    rd_reg(BASE + 24, r);
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
